uart_rx: RTL

//   Asynchronous serial receiver, 8 data bits, LSB first, 1 stop bit (8N1).

---
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with oversampled mid-bit sampling and valid/ready byte handoff.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check and parity_err output.
module uart_rx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
`ifdef UART_RX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    state_t        state;
    logic          rx_p0;
    logic          rx_s;
    logic [PW-1:0] pre;
    logic          tick;
    logic [SW-1:0] sc;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          done;
    logic          mid;
    logic          par_ok;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == DIV_LAST);
    assign mid  = (state == ST_START) ? (sc == MID_START) : (sc == MID_BIT);
    assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (tick && mid && state == ST_PARITY) begin
            par_bit <= rx_s;
        end
    end

    assign par_ok = ~(^{shift, par_bit});
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (tick && mid && state == ST_DATA) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sc        <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick) begin
                if (state != ST_IDLE && state != ST_BREAK && !mid) begin
                    sc <= sc + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            sc    <= '0;
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (mid) begin
                            if (rx_s) begin
                                state <= ST_IDLE;
                            end else begin
                                sc      <= '0;
                                bit_idx <= '0;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (mid) begin
                            sc      <= '0;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (mid) begin
                            sc    <= '0;
                            state <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (mid) begin
                            sc <= '0;
                            // Framing error wins over a parity mismatch
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
                                parity_err <= 1'b1;
`endif
                                state <= ST_IDLE;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Holding register: a simultaneous handoff frees the slot for the new byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
